asu_ddr5_read_phase_packer: RTL
===============================

Name: asu_ddr5_read_phase_packer

Overview:
- Read-path counterpart of the write-side frequency-ratio serializer.
- Collects one read-data beat per PHY clock from the DRAM-side datapath and packs consecutive beats into DFI read phases w0..w3 for the memory controller.
- Packing depth follows the DFI frequency ratio: 1:1, 1:2 or 1:4.
- Sits between the PHY read capture logic and the DFI read interface.

Parameters:
pDRAM_SIZE, 4, DRAM device width; read beat width is 2*pDRAM_SIZE bits.

Ports:
clk_i  input  1  PHY clock.
rst_i  input  1  async active-low reset; asynchronous assertion, release sampled on clk_i.
enable_i  input  1  block enable.
dfi_freq_ratio_i  input  3  000=1:1 (N=1), 001=1:2 (N=2), 010=1:4 (N=4); 011..111 reserved, treated as 1:1.
rddata_i  input  2*pDRAM_SIZE  read beat for the current PHY cycle.
rddata_valid_i  input  1  beat valid.
dfi_rddata_w0_o..dfi_rddata_w3_o  output  2*pDRAM_SIZE each  packed phase data.
dfi_rddata_valid_w0_o..dfi_rddata_valid_w3_o  output  1 each  packed phase valid.
dfi_group_strobe_o  output  1  one-cycle pulse: new packed group presented.

Behaviour:
Internal state:
- Phase counter cnt, 2 bits.
- Active ratio register N.
- Slot registers slot_data[0..2] and slot_valid[0..2]; the last slot bypasses directly to the outputs.

Reset (rst_i=0, asynchronous):
- cnt=0; N=1 (1:1).
- All slots, all w0..w3 data/valid outputs and dfi_group_strobe_o = 0.
- Applies immediately, mid-group included; the partial group is discarded.

Ratio load:
- N is loaded from dfi_freq_ratio_i on any edge where enable_i=0, or where enable_i=1 and cnt==N-1 (group boundary).
- The new ratio takes effect for the next group. No change mid-group.

Enabled edge (enable_i=1):
- If cnt<N-1: slot[cnt] <= {rddata_i, rddata_valid_i}; cnt <= cnt+1; dfi_group_strobe_o <= 0.
- If cnt==N-1:
  - w(k) <= slot[k] for k<N-1.
  - w(N-1) <= {rddata_i, rddata_valid_i} (bypass).
  - w(k) <= 0 for k>=N.
  - cnt <= 0; dfi_group_strobe_o <= 1.
- Counter is clock-aligned, free-running while enabled. Groups are not realigned to valid; invalid beats are packed with valid=0 and their data passed through unchanged.

Disabled edge (enable_i=0):
- cnt <= 0; partial group discarded.
- Packed outputs hold their last value; dfi_group_strobe_o <= 0.
- Re-enable restarts packing at slot 0.

Latency and hold:
- Latency is 1 clk from the last beat of a group to the outputs.
- 1:1: w0 = previous-cycle beat and dfi_group_strobe_o stays high continuously.
- Outputs hold stable for the N-1 cycles between strobes.

Simultaneous events:
- Reset overrides everything.
- Enable falling on a boundary edge: the group completes only if enable_i=1 at that edge.

Test Plan:
1. Reset with ratio 010 and data toggling -> all w outputs 0, valids 0, strobe 0. Assert rst_i low mid-group -> outputs clear before the next clk edge.
2. Ratio 010, enable from cnt 0, beats 01,02,03,04 with valid 1,0,0,1 -> one cycle after the 4th beat: w0..w3 = 01,02,03,04; valid_w = 1,0,0,1; strobe=1 for exactly 1 cycle. Values held for the next 3 cycles.
3. Ratio 001, beats AA,55,3C,C3 -> strobe every 2nd cycle. Groups w0/w1 = AA/55 then 3C/C3; w2=w3=0 with valid 0.
4. Ratio 000, beats 11,22,33 -> strobe constantly high; w0 = 11,22,33 each one cycle late; w1..w3 = 0.
5. Ratio 010, enable_i drops after 2 beats -> no strobe, outputs hold previous group. Re-enable with beats 05,06,07,08 -> group w0..w3 = 05,06,07,08.
6. Ratio switched 010->001 at beat 2 of a group -> current group completes as 1:4. Following groups pack 2 beats, with w2/w3 = 0.

Source files
------------

// File: rtl/asu_ddr5_read_phase_packer_if.sv
// Read-beat input and DFI packed-phase output bundle for the read phase packer.
// The slave modport belongs to the packer; the master modport belongs to its environment.
interface asu_ddr5_read_phase_packer_if #(
    parameter int pDRAM_SIZE = 4
);
    logic [2*pDRAM_SIZE-1:0] rddata;
    logic                    rddata_valid;
    logic [2*pDRAM_SIZE-1:0] dfi_rddata_w0;
    logic [2*pDRAM_SIZE-1:0] dfi_rddata_w1;
    logic [2*pDRAM_SIZE-1:0] dfi_rddata_w2;
    logic [2*pDRAM_SIZE-1:0] dfi_rddata_w3;
    logic                    dfi_rddata_valid_w0;
    logic                    dfi_rddata_valid_w1;
    logic                    dfi_rddata_valid_w2;
    logic                    dfi_rddata_valid_w3;
    logic                    dfi_group_strobe;

    modport master (
        output rddata, rddata_valid,
        input  dfi_rddata_w0, dfi_rddata_w1, dfi_rddata_w2, dfi_rddata_w3,
        input  dfi_rddata_valid_w0, dfi_rddata_valid_w1,
        input  dfi_rddata_valid_w2, dfi_rddata_valid_w3,
        input  dfi_group_strobe
    );

    modport slave (
        input  rddata, rddata_valid,
        output dfi_rddata_w0, dfi_rddata_w1, dfi_rddata_w2, dfi_rddata_w3,
        output dfi_rddata_valid_w0, dfi_rddata_valid_w1,
        output dfi_rddata_valid_w2, dfi_rddata_valid_w3,
        output dfi_group_strobe
    );
endinterface

// File: rtl/asu_ddr5_read_phase_packer.sv
// Packs one read beat per PHY clock into DFI read phases w0..w3 according to
// the 1:1 / 1:2 / 1:4 frequency ratio; the last beat of a group bypasses the slots.
module asu_ddr5_read_phase_packer #(
    parameter int pDRAM_SIZE = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  enable_i,
    input  logic [2:0]                            dfi_freq_ratio_i,
    asu_ddr5_read_phase_packer_if.slave           bus
);
    localparam int W = 2 * pDRAM_SIZE;

    // Ratio is held as the index of the last phase (N-1), which is also the boundary count.
    typedef enum logic [1:0] {
        RATIO_1_1 = 2'd0,
        RATIO_1_2 = 2'd1,
        RATIO_1_4 = 2'd3
    } ratio_e;

    ratio_e         ratio_q, ratio_d, ratio_in;
    logic [1:0]     cnt_q, cnt_d;
    logic [W-1:0]   slot_data_q [3];
    logic [W-1:0]   slot_data_d [3];
    logic [2:0]     slot_valid_q, slot_valid_d;
    logic [W-1:0]   w_data_q [4];
    logic [W-1:0]   w_data_d [4];
    logic [3:0]     w_valid_q, w_valid_d;
    logic           strobe_q, strobe_d;
    logic           boundary;

    always_comb begin
        unique case (dfi_freq_ratio_i)
            3'b001:  ratio_in = RATIO_1_2;
            3'b010:  ratio_in = RATIO_1_4;
            default: ratio_in = RATIO_1_1;
        endcase
    end

    assign boundary = (cnt_q == ratio_q);

    always_comb begin
        ratio_d      = ratio_q;
        cnt_d        = cnt_q;
        slot_data_d  = slot_data_q;
        slot_valid_d = slot_valid_q;
        w_data_d     = w_data_q;
        w_valid_d    = w_valid_q;
        strobe_d     = 1'b0;

        if (!enable_i) begin
            cnt_d   = '0;
            ratio_d = ratio_in;
        end else if (boundary) begin
            // Phases beyond the active ratio are zeroed, then the slots and the bypassed beat fill the rest.
            for (int unsigned k = 0; k < 4; k++) begin
                w_data_d[k]  = '0;
                w_valid_d[k] = 1'b0;
            end
            for (int unsigned k = 0; k < 3; k++) begin
                if (2'(k) < ratio_q) begin
                    w_data_d[k]  = slot_data_q[k];
                    w_valid_d[k] = slot_valid_q[k];
                end
            end
            w_data_d[ratio_q]  = bus.rddata;
            w_valid_d[ratio_q] = bus.rddata_valid;
            cnt_d    = '0;
            strobe_d = 1'b1;
            ratio_d  = ratio_in;
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (cnt_q == 2'(k)) begin
                    slot_data_d[k]  = bus.rddata;
                    slot_valid_d[k] = bus.rddata_valid;
                end
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ratio_q      <= RATIO_1_1;
            cnt_q        <= '0;
            slot_valid_q <= '0;
            w_valid_q    <= '0;
            strobe_q     <= 1'b0;
            for (int unsigned k = 0; k < 3; k++) slot_data_q[k] <= '0;
            for (int unsigned k = 0; k < 4; k++) w_data_q[k] <= '0;
        end else begin
            ratio_q      <= ratio_d;
            cnt_q        <= cnt_d;
            slot_valid_q <= slot_valid_d;
            w_valid_q    <= w_valid_d;
            strobe_q     <= strobe_d;
            for (int unsigned k = 0; k < 3; k++) slot_data_q[k] <= slot_data_d[k];
            for (int unsigned k = 0; k < 4; k++) w_data_q[k] <= w_data_d[k];
        end
    end

    assign bus.dfi_rddata_w0       = w_data_q[0];
    assign bus.dfi_rddata_w1       = w_data_q[1];
    assign bus.dfi_rddata_w2       = w_data_q[2];
    assign bus.dfi_rddata_w3       = w_data_q[3];
    assign bus.dfi_rddata_valid_w0 = w_valid_q[0];
    assign bus.dfi_rddata_valid_w1 = w_valid_q[1];
    assign bus.dfi_rddata_valid_w2 = w_valid_q[2];
    assign bus.dfi_rddata_valid_w3 = w_valid_q[3];
    assign bus.dfi_group_strobe    = strobe_q;
endmodule
